// File: rtl/idma_2d_req_arbiter_if.sv
// Bundle of the arbiter's frontend and midend signals.
//   req_i / req_valid_i / req_ready_o : per-port 2D request handshake (frontends)
//   twod_req_o / _valid_o / _ready_i  : shared 2D request handshake (midend)
//   done_i / done_o                   : in-order completion in, per-port pulse out
//   outstanding_o                     : per-port in-flight count
//   err_o                             : completion seen with nothing in flight
// slave is the arbiter side; master is the environment driving it.
interface idma_2d_req_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned CW         = 3,
  parameter type         twod_req_t = logic
);
  twod_req_t              req_i [NUM_PORTS];
  logic [NUM_PORTS-1:0]   req_valid_i;
  logic [NUM_PORTS-1:0]   req_ready_o;
  twod_req_t              twod_req_o;
  logic                   twod_req_valid_o;
  logic                   twod_req_ready_i;
  logic                   done_i;
  logic [NUM_PORTS-1:0]   done_o;
  logic [CW-1:0]          outstanding_o [NUM_PORTS];
  logic                   err_o;

  modport slave (
    input  req_i, req_valid_i, twod_req_ready_i, done_i,
    output req_ready_o, twod_req_o, twod_req_valid_o, done_o, outstanding_o, err_o
  );

  modport master (
    output req_i, req_valid_i, twod_req_ready_i, done_i,
    input  req_ready_o, twod_req_o, twod_req_valid_o, done_o, outstanding_o, err_o
  );
endinterface

// File: rtl/idma_2d_req_arbiter.sv
// Round-robin arbiter sharing one 2D-request midend among NUM_PORTS frontends.
// Accepted requests pass through combinationally; the origin port of each one is
// kept in an in-order FIFO so that in-order completions (done_i) can be routed
// back to the right frontend one cycle later.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : idma_2d_req_arbiter_if.slave (request/response signals)
module idma_2d_req_arbiter #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned ORDER_DEPTH     = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter type         twod_req_t      = logic
) (
  input logic                    clk_i,
  input logic                    rst_i,
  idma_2d_req_arbiter_if.slave   bus
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned OW = $clog2(ORDER_DEPTH + 1);

  logic                 lock_q;
  logic [PW-1:0]        lock_port_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        fifo_mem_q [ORDER_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [OW-1:0]        occ_q;
  logic [CW-1:0]        cnt_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] done_q;
  logic                 err_q;

  logic [NUM_PORTS-1:0] eligible;
  logic                 arb_found;
  logic [PW-1:0]        arb_sel;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        head;
  logic                 full, empty, valid, push, pop;
  twod_req_t            sel_req;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = bus.req_valid_i[p] && (cnt_q[p] < CW'(MAX_OUTSTANDING));
    end
  end

  // First eligible port at or above the pointer, wrapping around.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    arb_found = 1'b0;
    arb_sel   = '0;
    idx       = 0;
    idx_p     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_p = PW'(idx);
      if (!arb_found && eligible[idx_p]) begin
        arb_found = 1'b1;
        arb_sel   = idx_p;
      end
    end
  end

  assign full    = (occ_q == OW'(ORDER_DEPTH));
  assign empty   = (occ_q == '0);
  assign sel     = lock_q ? lock_port_q : arb_sel;
  // A lock implies the FIFO had room when it was taken, and it only fills on a push.
  assign valid   = !rst_i && (lock_q || arb_found) && !full;
  assign push    = valid && bus.twod_req_ready_i;
  assign head    = fifo_mem_q[rd_q];
  assign pop     = bus.done_i && !empty;
  assign sel_req = bus.req_i[sel];

  assign bus.twod_req_o       = sel_req;
  assign bus.twod_req_valid_o = valid;
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.req_ready_o[p]   = push && (sel == PW'(p));
      bus.outstanding_o[p] = cnt_q[p];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      ptr_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < ORDER_DEPTH; i++) fifo_mem_q[i] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      if (push) begin
        lock_q         <= 1'b0;
        fifo_mem_q[wr_q] <= sel;
        wr_q           <= (wr_q == AW'(ORDER_DEPTH - 1)) ? '0 : wr_q + AW'(1);
        ptr_q          <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
      end else if (valid) begin
        lock_q      <= 1'b1;
        lock_port_q <= sel;
      end
      if (pop) rd_q <= (rd_q == AW'(ORDER_DEPTH - 1)) ? '0 : rd_q + AW'(1);
      occ_q <= occ_q + OW'(push) - OW'(pop);
      for (int p = 0; p < NUM_PORTS; p++) begin
        // Simultaneous increment and decrement on one port cancel out.
        if (push && (sel == PW'(p)) && !(pop && (head == PW'(p)))) begin
          cnt_q[p] <= cnt_q[p] + CW'(1);
        end else if (pop && (head == PW'(p)) && !(push && (sel == PW'(p)))) begin
          cnt_q[p] <= cnt_q[p] - CW'(1);
        end
        done_q[p] <= pop && (head == PW'(p));
      end
      err_q <= bus.done_i && empty;
    end
  end
endmodule

// File: tb/tb_idma_2d_req_arbiter.sv
module tb_idma_2d_req_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int MAXO  = 4;
  localparam int CW    = 3;
  typedef logic [15:0] data_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idma_2d_req_arbiter_if #(.NUM_PORTS(N), .CW(CW), .twod_req_t(data_t)) bus ();

  idma_2d_req_arbiter #(
    .NUM_PORTS(N), .ORDER_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .twod_req_t(data_t)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: origin queue, per-port counts, pointer and pending-offer lock.
  int         q[$];
  int         cnt[N];
  int         ptr;
  bit         locked;
  int         lock_port;
  logic [N-1:0] m_done;
  bit         m_err;
  // Expectations for the current cycle.
  bit         e_valid;
  int         e_sel;
  logic [N-1:0] e_ready;
  data_t      data[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int p = 0; p < N; p++) cnt[p] = 0;
    ptr = 0; locked = 0; lock_port = 0; m_done = '0; m_err = 0;
  endtask

  task automatic model_eval(input logic [N-1:0] v, input bit r);
    bit found = 0;
    int s = 0;
    if (locked) begin
      found = 1; s = lock_port;
    end else begin
      for (int i = 0; i < N; i++) begin
        int idx = (ptr + i) % N;
        if (!found && v[idx] && cnt[idx] < MAXO) begin found = 1; s = idx; end
      end
    end
    e_valid = found && (q.size() < DEPTH);
    e_sel   = found ? s : 0;
    e_ready = (e_valid && r) ? N'(1 << s) : '0;
  endtask

  task automatic model_update(input bit r, input bit d);
    logic [N-1:0] nd = '0;
    bit ne = 0;
    if (d) begin
      if (q.size() > 0) begin
        int h = q.pop_front();
        nd[h] = 1'b1;
        cnt[h]--;
      end else begin
        ne = 1;
      end
    end
    if (e_valid && r) begin
      q.push_back(e_sel);
      cnt[e_sel]++;
      ptr = (e_sel + 1) % N;
      locked = 0;
    end else if (e_valid) begin
      locked = 1; lock_port = e_sel;
    end
    m_done = nd; m_err = ne;
  endtask

  task automatic cycle(input logic [N-1:0] v, input bit r, input bit d);
    @(posedge clk); #1;
    bus.req_valid_i = v; bus.twod_req_ready_i = r; bus.done_i = d;
    for (int p = 0; p < N; p++) bus.req_i[p] = data[p];
    @(negedge clk);
    model_eval(v, r);
    check("valid", 32'(bus.twod_req_valid_o), 32'(e_valid));
    check("payload", 32'(bus.twod_req_o), 32'(data[e_sel]));
    check("req_ready", 32'(bus.req_ready_o), 32'(e_ready));
    check("done_o", 32'(bus.done_o), 32'(m_done));
    check("err_o", 32'(bus.err_o), 32'(m_err));
    for (int p = 0; p < N; p++) check("outstanding", 32'(bus.outstanding_o[p]), 32'(cnt[p]));
    model_update(r, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0; bus.twod_req_ready_i = 1'b0; bus.done_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.twod_req_valid_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_out1", 32'(bus.outstanding_o[1]), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] v;
    bit           r;
    bit           d;
    bit           ev;
    int           es;
    logic [N-1:0] er;
    logic [N-1:0] edn;
    bit           eer;
  } vec_t;

  vec_t tbl[9];
  logic [N-1:0] pending;

  initial begin
    bus.req_valid_i = '0; bus.twod_req_ready_i = 1'b0; bus.done_i = 1'b0;
    for (int p = 0; p < N; p++) begin data[p] = data_t'(16'hA000 + p); bus.req_i[p] = data[p]; end

    // Table: err after empty done, rotation, lock on port 2, pointer wrap.
    tbl[0] = '{4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0};
    tbl[1] = '{4'b1111, 1, 0, 1, 0, 4'b0001, 4'b0000, 1};
    tbl[2] = '{4'b1111, 1, 1, 1, 1, 4'b0010, 4'b0000, 0};
    tbl[3] = '{4'b1111, 1, 1, 1, 2, 4'b0100, 4'b0001, 0};
    tbl[4] = '{4'b1111, 1, 0, 1, 3, 4'b1000, 4'b0010, 0};
    tbl[5] = '{4'b0100, 0, 0, 1, 2, 4'b0000, 4'b0000, 0};
    tbl[6] = '{4'b0101, 0, 0, 1, 2, 4'b0000, 4'b0000, 0};
    tbl[7] = '{4'b0101, 1, 0, 1, 2, 4'b0100, 4'b0000, 0};
    tbl[8] = '{4'b0001, 1, 0, 1, 0, 4'b0001, 4'b0000, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].d);
      check("tbl_valid", 32'(bus.twod_req_valid_o), 32'(tbl[i].ev));
      check("tbl_payload", 32'(bus.twod_req_o), 32'(16'hA000 + tbl[i].es));
      check("tbl_ready", 32'(bus.req_ready_o), 32'(tbl[i].er));
      check("tbl_done", 32'(bus.done_o), 32'(tbl[i].edn));
      check("tbl_err", 32'(bus.err_o), 32'(tbl[i].eer));
    end

    // Per-port cap.
    do_reset();
    repeat (4) cycle(4'b0010, 1, 0);
    cycle(4'b1010, 1, 0);
    check("cap_out1", 32'(bus.outstanding_o[1]), 32'd4);
    check("cap_ready", 32'(bus.req_ready_o), 32'b1000);
    cycle(4'b0010, 1, 1);
    check("cap_blocked", 32'(bus.twod_req_valid_o), 32'd0);
    cycle(4'b0010, 1, 0);
    check("cap_done", 32'(bus.done_o), 32'b0010);
    check("cap_regrant", 32'(bus.req_ready_o), 32'b0010);

    // FIFO full, with done and a new request in the same cycle.
    do_reset();
    repeat (8) cycle(4'b1111, 1, 0);
    cycle(4'b1111, 1, 0);
    check("full_valid", 32'(bus.twod_req_valid_o), 32'd0);
    cycle(4'b1111, 1, 1);
    check("full_pop_valid", 32'(bus.twod_req_valid_o), 32'd0);
    cycle(4'b1111, 1, 0);
    check("full_retry", 32'(bus.twod_req_valid_o), 32'd1);
    cycle(4'b1111, 1, 0);
    check("full_again", 32'(bus.twod_req_valid_o), 32'd0);

    // Error pulse and same-port push/pop.
    do_reset();
    cycle(4'b0000, 0, 1);
    cycle(4'b0001, 1, 0);
    check("err_pulse", 32'(bus.err_o), 32'd1);
    cycle(4'b0001, 1, 1);
    check("err_once", 32'(bus.err_o), 32'd0);
    cycle(4'b0000, 0, 0);
    check("simul_out0", 32'(bus.outstanding_o[0]), 32'd1);

    // Asynchronous reset mid-operation.
    do_reset();
    repeat (5) cycle(4'b1111, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.twod_req_valid_o), 32'd0);
    check("arst_ready", 32'(bus.req_ready_o), 32'd0);
    check("arst_out0", 32'(bus.outstanding_o[0]), 32'd0);
    check("arst_done", 32'(bus.done_o), 32'd0);
    model_reset();
    bus.req_valid_i = '0;
    #3 rst = 1'b0;
    cycle(4'b1110, 1, 0);
    check("arst_first", 32'(bus.req_ready_o), 32'b0010);

    // Randomized traffic with valid/data held until accepted.
    do_reset();
    pending = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pending[p] && $urandom_range(0, 99) < 40) begin
          pending[p] = 1'b1;
          data[p] = data_t'($urandom);
        end
      end
      cycle(pending, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35);
      pending = pending & ~e_ready;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/idma_2d_req_arbiter.md
Name: idma_2d_req_arbiter

Overview:
- N-port round-robin arbiter that shares one 2D-request midend among several frontends (e.g. per-core DMA register files).
- Forwards one `twod_req_t` at a time to the midend's 2D request input.
- Records the origin port of each accepted request in an in-order ID FIFO.
- Routes the backend's in-order transfer-completion pulses back to the originating port.

Parameters:
- NUM_PORTS, 4, number of requesting frontends (>=2).
- ORDER_DEPTH, 8, depth of the origin-port FIFO; caps total in-flight 2D transfers.
- MAX_OUTSTANDING, 4, per-port cap on in-flight 2D transfers (>=1).
- twod_req_t, logic, 2D request struct, passed through unmodified.
- Derived: PW = max(1, $clog2(NUM_PORTS)); CW = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS x twod_req_t  per-port 2D request.
- req_valid_i  in  NUM_PORTS  per-port request valid.
- req_ready_o  out  NUM_PORTS  per-port accept; one-hot or zero.
- twod_req_o  out  twod_req_t  request to midend.
- twod_req_valid_o  out  1  request valid to midend.
- twod_req_ready_i  in  1  midend accept.
- done_i  in  1  single-cycle pulse: oldest in-flight 2D transfer finished (in order).
- done_o  out  NUM_PORTS  one-cycle completion pulse to originating port.
- outstanding_o  out  NUM_PORTS x CW  per-port in-flight count.
- err_o  out  1  one-cycle pulse: done_i received with ID FIFO empty.

Behaviour:
- Reset (async, rst_i=1), all cleared immediately:
  - Lock flag = 0; grant register = 0; round-robin pointer = 0.
  - ID FIFO empty; all outstanding counters = 0.
  - done_o = 0; err_o = 0; twod_req_valid_o = 0; req_ready_o = 0.
  - In-flight transfers are forgotten; later done_i pulses raise err_o.
- Eligibility: port p is eligible iff req_valid_i[p] && outstanding[p] < MAX_OUTSTANDING.
- Selection (combinational, unlocked):
  - First eligible port searching upward from pointer, wrapping at NUM_PORTS-1 to 0.
  - twod_req_valid_o = any eligible && !fifo_full.
  - twod_req_o = req_i[sel].
  - When no port is eligible, twod_req_o = req_i[0] and valid = 0.
- Lock:
  - If twod_req_valid_o && !twod_req_ready_i, register sel and set the lock.
  - While locked, sel = the registered port regardless of other ports; valid stays high and payload stays stable.
  - Requesters must hold valid and data until ready (standard valid/ready).
  - Lock clears on handshake.
- Handshake (twod_req_valid_o && twod_req_ready_i):
  - req_ready_o[sel] = twod_req_ready_i && !fifo_full && grant; all other bits 0.
  - Push sel into the ID FIFO.
  - outstanding[sel] += 1.
  - Pointer = sel+1, wrapping to 0 past NUM_PORTS-1.
  - Zero-cycle passthrough: the request is visible to the midend the same cycle.
- FIFO full:
  - twod_req_valid_o is forced low, even if done_i pops the FIFO in the same cycle.
  - The push is retried next cycle.
  - A lock taken before full cannot coexist with full: the FIFO can only fill on a push, and a push clears the lock.
- Completion:
  - On done_i with FIFO non-empty: pop the head h; done_o[h] = 1 in the next cycle (1-cycle registered latency); outstanding[h] -= 1.
  - On done_i with FIFO empty: nothing popped, no counter change; err_o = 1 next cycle.
- Simultaneous events:
  - Push and pop in the same cycle with FIFO not full: both occur, occupancy unchanged.
  - Handshake and done on the same port in the same cycle: outstanding unchanged.
  - Counters never wrap: the increment is gated by eligibility; the decrement is gated by FIFO non-empty, which implies count > 0.
- No combinational path from done_i to any output. The only comb paths are req_valid_i/req_i/twod_req_ready_i → twod_req_valid_o/twod_req_o/req_ready_o.

Test Plan:
- Fairness: ports 0–3 request continuously; ready=1; done_i pulsed every cycle from cycle 2 → grant order 0,1,2,3,0,…; each port receives 1/4 of grants; done_o follows grant order with a 1-cycle lag after each done_i.
- Lock: port 2 valid, ready held 0 for 5 cycles; port 0 asserts valid in cycle 2 → twod_req_o stays req_i[2] and valid stays high all 5 cycles; port 2 handshakes when ready=1; port 0 is served the next cycle.
- Per-port cap (MAX_OUTSTANDING=4): port 1 issues 4 requests with no done_i → outstanding_o[1]=4, req_ready_o[1]=0 with valid held; port 3 is still granted; one done_i → done_o[1] pulses, count=3, port 1 is granted again.
- FIFO full (ORDER_DEPTH=8): 8 handshakes spread over ports, no done_i → twod_req_valid_o=0; done_i plus new request in the same cycle → no grant that cycle, grant on the next cycle; occupancy returns to 8.
- Error and simultaneous: done_i after reset with FIFO empty → err_o pulses once, counters stay 0; handshake on port 0 in the same cycle as done_i for port 0 → outstanding_o[0] unchanged.
- Reset mid-operation: assert rst_i asynchronously (off clock edge) with 5 in flight → outputs clear immediately; after release, first grant goes to the lowest-index eligible port, starting from port 0.
